// File: rtl/iir_mac_scheduler.sv
// Sequencer for the shared biquad MAC: walks every channel through LOAD, TAPS MAC cycles
// and WRITE per accepted sample, then pulses the output-phase strobe in DONE.
module iir_mac_scheduler #(
    parameter int NUM_CH = 3,
    parameter int TAPS   = 5,
    parameter int CH_W   = 2,
    parameter int TAP_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             sample_valid,
    input  logic             clr_ovr,
    output logic             enb,
    output logic             enb_1_3_0,
    output logic [CH_W-1:0]  ch_sel,
    output logic [TAP_W-1:0] tap_addr,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             state_we,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_cnt, ch_d;
    logic [TAP_W-1:0]   tap_cnt, tap_d;
    logic               drop;

    logic               busy_d, mac_en_d, mac_clr_d, state_we_d, done_d, overrun_d;
    logic [CH_W-1:0]    ch_sel_d;
    logic [TAP_W-1:0]   tap_addr_d;

    // sample_valid is a one-cycle strobe with no back-pressure: it is accepted only in
    // IDLE or DONE; any strobe seen while busy is dropped and recorded in overrun.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_cnt;
        tap_d   = tap_cnt;
        drop    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (sample_valid) begin
                    state_d = S_LOAD;
                    ch_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                drop    = sample_valid;
                tap_d   = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                drop = sample_valid;
                if (tap_cnt >= TAP_LAST) begin
                    state_d = S_WRITE;
                end else begin
                    tap_d = tap_cnt + 1'b1;
                end
            end
            S_WRITE: begin
                drop = sample_valid;
                if (ch_cnt >= CH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_cnt + 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                ch_d    = '0;
                tap_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered versions line up with state_q.
    always_comb begin
        busy_d     = (state_d == S_LOAD) || (state_d == S_MAC) || (state_d == S_WRITE);
        mac_en_d   = (state_d == S_MAC);
        mac_clr_d  = (state_d == S_MAC) && (tap_d == '0);
        state_we_d = (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        ch_sel_d   = busy_d ? ch_d : ch_sel;
        tap_addr_d = mac_en_d ? tap_d : tap_addr;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ch_cnt    <= '0;
            tap_cnt   <= '0;
            busy      <= 1'b0;
            mac_en    <= 1'b0;
            mac_clr   <= 1'b0;
            state_we  <= 1'b0;
            out_valid <= 1'b0;
            enb_1_3_0 <= 1'b0;
            ch_sel    <= '0;
            tap_addr  <= '0;
            overrun   <= 1'b0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            ch_cnt    <= ch_d;
            tap_cnt   <= tap_d;
            busy      <= busy_d;
            mac_en    <= mac_en_d;
            mac_clr   <= mac_clr_d;
            state_we  <= state_we_d;
            out_valid <= done_d;
            enb_1_3_0 <= done_d;
            ch_sel    <= ch_sel_d;
            tap_addr  <= tap_addr_d;
            overrun   <= overrun_d;
        end
    end

    assign enb       = clk_enable;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Bench for iir_mac_scheduler: position-based reference model, out_valid timing
// scoreboard, and a second small-parameter instance for the sweep case.
module tb_iir_mac_scheduler;

    localparam int N    = 3;
    localparam int T    = 5;
    localparam int SEG  = T + 2;
    localparam int LAST = N * SEG;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b1;
    logic sv = 1'b0;
    logic clr = 1'b0;
    logic sv2 = 1'b0;

    logic       enb, enb_1_3_0, mac_clr, mac_en, state_we, out_valid, busy, overrun;
    logic [1:0] ch_sel;
    logic [2:0] tap_addr, dbg_state;

    logic       enb2, enb_1_3_0_2, mac_clr2, mac_en2, state_we2, out_valid2, busy2, overrun2;
    logic [0:0] ch_sel2;
    logic [1:0] tap_addr2;
    logic [2:0] dbg_state2;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int frz_adj  = 0;
    logic [31:0] exp_q[$];

    // reference model: position inside the current sample sequence
    logic m_active = 1'b0;
    int   m_pos = 0;
    logic m_ovr = 1'b0;
    int   m_ch = 0;
    int   m_tap = 0;

    iir_mac_scheduler #(.NUM_CH(3), .TAPS(5), .CH_W(2), .TAP_W(3)) dut (
        .clk(clk), .reset(rst_n), .clk_enable(ce), .sample_valid(sv), .clr_ovr(clr),
        .enb(enb), .enb_1_3_0(enb_1_3_0), .ch_sel(ch_sel), .tap_addr(tap_addr),
        .mac_clr(mac_clr), .mac_en(mac_en), .state_we(state_we), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    iir_mac_scheduler #(.NUM_CH(2), .TAPS(3), .CH_W(1), .TAP_W(2)) dut2 (
        .clk(clk), .reset(rst_n), .clk_enable(ce), .sample_valid(sv2), .clr_ovr(clr),
        .enb(enb2), .enb_1_3_0(enb_1_3_0_2), .ch_sel(ch_sel2), .tap_addr(tap_addr2),
        .mac_clr(mac_clr2), .mac_en(mac_en2), .state_we(state_we2), .out_valid(out_valid2),
        .busy(busy2), .overrun(overrun2), .dbg_state(dbg_state2)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        logic a;
        int   p;
        logic o;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_ovr    <= 1'b0;
            m_ch     <= 0;
            m_tap    <= 0;
        end else if (ce) begin
            a = m_active;
            p = m_pos;
            o = m_ovr;
            if (a && p < LAST) begin
                if (sv) o = 1'b1;
                else if (clr) o = 1'b0;
                p = p + 1;
            end else begin
                if (clr) o = 1'b0;
                a = sv;
                p = 0;
            end
            if (a && p < LAST) begin
                m_ch <= p / SEG;
                if ((p % SEG) >= 1 && (p % SEG) <= T) m_tap <= (p % SEG) - 1;
            end
            m_active <= a;
            m_pos    <= p;
            m_ovr    <= o;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        logic in_seq, is_done, is_mac;
        int   r;
        int   st;
        in_seq  = m_active && (m_pos < LAST);
        is_done = m_active && (m_pos == LAST);
        r       = m_pos % SEG;
        is_mac  = in_seq && r >= 1 && r <= T;
        if (!m_active)    st = 0;
        else if (is_done) st = 4;
        else if (r == 0)  st = 1;
        else if (is_mac)  st = 2;
        else              st = 3;
        check("enb", 32'(enb), 32'(ce));
        check("busy", 32'(busy), 32'(in_seq));
        check("mac_en", 32'(mac_en), 32'(is_mac));
        check("mac_clr", 32'(mac_clr), 32'(in_seq && r == 1));
        check("state_we", 32'(state_we), 32'(in_seq && r == T + 1));
        check("out_valid", 32'(out_valid), 32'(is_done));
        check("enb_1_3_0", 32'(enb_1_3_0), 32'(is_done));
        check("ch_sel", 32'(ch_sel), 32'(m_ch));
        check("tap_addr", 32'(tap_addr), 32'(m_tap));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("state", 32'(dbg_state), 32'(st));
        // scoreboard: each out_valid pulse must match the next expected cycle stamp
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) check("ov_unexpected", 32'd1, 32'd0);
            else check("ov_time", 32'(cyc), exp_q.pop_front());
        end
    endtask

    // driver: compare the current cycle, then drive inputs for it
    task automatic tick(input logic s, input logic e, input logic c);
        @(negedge clk);
        compare_all();
        if (s && e && rst_n && !(m_active && m_pos < LAST))
            exp_q.push_back(32'(cyc + LAST + 1 + frz_adj));
        sv  = s;
        ce  = e;
        clr = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // single sample
        tick(1'b1, 1'b1, 1'b0);
        idle(26);

        // back-to-back: second sample in the DONE cycle
        tick(1'b1, 1'b1, 1'b0);
        idle(21);
        tick(1'b1, 1'b1, 1'b0);
        idle(26);

        // overrun, then set-wins versus clear, then clear alone
        tick(1'b1, 1'b1, 1'b0);
        idle(9);
        tick(1'b1, 1'b1, 1'b0);
        idle(4);
        tick(1'b1, 1'b1, 1'b1);
        idle(10);
        tick(1'b0, 1'b1, 1'b1);
        idle(3);

        // freeze cycles 4..8 of the sequence
        frz_adj = 5;
        tick(1'b1, 1'b1, 1'b0);
        frz_adj = 0;
        idle(3);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
        idle(25);

        // random traffic
        for (int i = 0; i < 200; i++)
            tick(($urandom_range(0, 11) == 0), 1'b1, ($urandom_range(0, 9) == 0));
        idle(25);

        // reset mid-MAC of channel 1: the partial sample never produces out_valid
        tick(1'b1, 1'b1, 1'b0);
        idle(10);
        rst_n = 1'b0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(30);

        // small-parameter instance: NUM_CH=2, TAPS=3
        tick(1'b0, 1'b1, 1'b0);
        sv2 = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick(1'b0, 1'b1, 1'b0);
            sv2 = 1'b0;
            check("sw_state_we", 32'(state_we2), 32'(c == 5 || c == 10));
            check("sw_out_valid", 32'(out_valid2), 32'(c == 11));
            check("sw_busy", 32'(busy2), 32'(c >= 1 && c <= 10));
            if (c == 5)  check("sw_ch_sel0", 32'(ch_sel2), 32'd0);
            if (c == 10) check("sw_ch_sel1", 32'(ch_sel2), 32'd1);
        end

        check("ov_pending", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/iir_mac_scheduler.md
Name: iir_mac_scheduler

Overview:
- Time-multiplexed sequencer for the shared biquad MAC datapath of the digital IIR filter.
- On each accepted input sample, steps the shared MAC through every channel:
  - selects the channel;
  - walks the coefficient/tap addresses;
  - drives accumulate-clear and accumulate-enable;
  - writes back the section state.
- Then issues a one-cycle output-phase strobe (enb_1_3_0) so the output mux rate-transition registers capture all channel results together.
- Sits between the sample-rate front end and the MAC/state-RAM/output-mux datapath.

Parameters:
- NUM_CH, 3, number of channels sharing the MAC (2..15).
- TAPS, 5, MAC cycles per channel (b0, b1, b2, a1, a2).
- CH_W, 2, width of ch_sel; must satisfy 2^CH_W >= NUM_CH.
- TAP_W, 3, width of tap_addr; must satisfy 2^TAP_W >= TAPS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clk_enable  in  1  global enable; low freezes all state.
- sample_valid  in  1  new input sample available, single-cycle strobe.
- clr_ovr  in  1  clears the sticky overrun flag.
- enb  out  1  datapath enable, equals clk_enable (combinational).
- enb_1_3_0  out  1  output-phase strobe to the output-mux RT registers.
- ch_sel  out  CH_W  channel currently driving the MAC.
- tap_addr  out  TAP_W  coefficient/state tap index.
- mac_clr  out  1  clear accumulator, asserted with tap 0.
- mac_en  out  1  accumulate this cycle.
- state_we  out  1  write MAC result into channel section state.
- out_valid  out  1  all channels done for this sample.
- busy  out  1  sequencer not idle.
- overrun  out  1  sticky, a sample was dropped.

Behaviour:
- **Reset:** while reset=0, every output except enb is 0 and the FSM is in IDLE; enb tracks clk_enable even during reset.
- **Freeze:** when clk_enable=0, FSM, counters and all registered outputs hold. Strobes already high stay high until the next enabled cycle; they are qualified downstream by enb.
- **Registered outputs:** all outputs except enb are registered and decoded from the FSM state and counters.
- **FSM states:** IDLE, LOAD, MAC, WRITE, DONE. Counters ch_cnt (0..NUM_CH-1) and tap_cnt (0..TAPS-1).
- **Accept:**
  - sample_valid=1 in IDLE or DONE causes ch_cnt:=0 and moves to LOAD on the next edge.
  - sample_valid in LOAD, MAC or WRITE sets overrun; the sample is dropped and the sequence continues unaffected.
- **LOAD (1 cycle):**
  - ch_sel=ch_cnt, mac_en=0.
  - tap_cnt:=0; go to MAC.
- **MAC (TAPS cycles):**
  - mac_en=1, tap_addr=tap_cnt, mac_clr=1 only when tap_cnt=0.
  - tap_cnt increments; when tap_cnt=TAPS-1, go to WRITE.
- **WRITE (1 cycle):**
  - state_we=1, ch_sel held.
  - If ch_cnt=NUM_CH-1, go to DONE; otherwise ch_cnt+1 and go to LOAD.
- **DONE (1 cycle):**
  - out_valid=1 and enb_1_3_0=1.
  - Go to IDLE, or to LOAD if sample_valid is present.
- **busy:** 1 in LOAD, MAC and WRITE; 0 in IDLE and DONE.
- **Latency:**
  - sample accepted at edge k gives LOAD ch0 in cycle k+1 and out_valid in cycle k+NUM_CH*(TAPS+2)+1 (k+22 at defaults).
  - Minimum accepted sample period is NUM_CH*(TAPS+2)+1 cycles (22 at defaults); back-to-back acceptance is allowed in DONE.
- **Idle values:** ch_sel and tap_addr hold their last value outside LOAD/MAC/WRITE; no strobes are asserted in IDLE.
- **overrun flag:**
  - Cleared by clr_ovr=1.
  - If a drop event and clr_ovr occur in the same cycle, set wins.
- **Reset mid-sequence:** immediate return to IDLE with all strobes deasserted. The partial sample is discarded; no out_valid or enb_1_3_0 is issued for it.
- **Counter wrap:** ch_cnt and tap_cnt never exceed their limits. Illegal state encodings recover to IDLE.

Test Plan:
- **Reset and idle:** assert reset=0 mid-MAC of ch1, then release -> all outputs 0, state IDLE, no out_valid pulse afterwards.
- **Single sample, defaults:** sample_valid at cycle 0 -> LOAD at 1; mac_en cycles 2-6 with tap_addr 0..4 and mac_clr only at cycle 2; state_we at 7, 14, 21 with ch_sel 0, 1, 2; out_valid=enb_1_3_0=1 only at cycle 22; busy high cycles 1-21.
- **Back-to-back:** sample_valid at cycles 0 and 22 -> second LOAD at 23, second out_valid at 44, overrun stays 0.
- **Overrun:** sample_valid at cycles 0 and 10 -> overrun=1 from cycle 11, first sequence unchanged. clr_ovr and another drop in the same cycle -> overrun stays 1; clr_ovr alone -> 0 next cycle.
- **Freeze:** clk_enable=0 for 5 cycles starting at cycle 4 -> enb=0, tap_addr frozen at 2; out_valid shifts to cycle 27.
- **Parameter sweep:** NUM_CH=2, TAPS=3 -> out_valid at cycle 11, state_we at cycles 5 and 10.
